// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI target endpoint.
package spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2
  } state_t;

  // Bit positions inside the sticky error vector.
  localparam int ERR_ABORT = 2;
  localparam int ERR_UNDR  = 1;
  localparam int ERR_OVF   = 0;

  // Value bit_cnt holds when the eighth sample of a byte arrives.
  localparam logic [3:0] LAST_BIT = 4'd7;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer with a delayed copy for rise/fall pulse detection.
module spi_sync_edge #(
  parameter int SYNC_STG = 2,
  parameter bit RST_VAL  = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_sync,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STG-1:0] r_sync;
  logic                r_dly;

  // Synchronizer chain followed by one edge-detect flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= {SYNC_STG{RST_VAL}};
      r_dly  <= RST_VAL;
    end else begin
      r_sync <= {r_sync[SYNC_STG-2:0], i_async};
      r_dly  <= r_sync[SYNC_STG-1];
    end
  end

  assign o_sync = r_sync[SYNC_STG-1];
  assign o_rise = o_sync & ~r_dly;
  assign o_fall = ~o_sync & r_dly;

endmodule

// File: rtl/spi_slave.sv
// SPI target endpoint: oversampled SCLK/CS_N/MOSI, MSB-first 8-bit bytes,
// one-entry transmit buffer, multi-byte frames while CS_N stays low.
//
// state | meaning
// IDLE  | not selected, MISO tri-stated, waiting for CS_N fall
// LOAD  | one cycle: fetch first tx byte, present its MSB
// SHIFT | selected: sample/shift on SCLK edges until CS_N rises
module spi_slave
  import spi_pkg::*;
#(
  parameter bit         CPOL      = 1'b0,
  parameter bit         CPHA      = 1'b0,
  parameter int         SYNC_STG  = 2,
  parameter logic [7:0] IDLE_BYTE = 8'hFF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic       cs_n,
  input  logic       mosi,
  output logic       miso,
  output logic       miso_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_load,
  output logic       tx_empty,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy,
  output logic [2:0] err
);

  logic w_sclk_s, w_sclk_rise, w_sclk_fall;
  logic w_cs_s, w_cs_rise, w_cs_fall;
  logic [SYNC_STG-1:0] r_mosi_sync;
  logic w_mosi_s;

  spi_sync_edge #(.SYNC_STG(SYNC_STG), .RST_VAL(CPOL)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .i_async(sclk),
    .o_sync(w_sclk_s), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
  );

  spi_sync_edge #(.SYNC_STG(SYNC_STG), .RST_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst_n(rst_n), .i_async(cs_n),
    .o_sync(w_cs_s), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
  );

  // MOSI only needs the synchronizer; it lines up with the sclk_s stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_mosi_sync <= '0;
    else        r_mosi_sync <= {r_mosi_sync[SYNC_STG-2:0], mosi};
  end
  assign w_mosi_s = r_mosi_sync[SYNC_STG-1];

  // Leading edge moves SCLK away from its idle level.
  logic w_sclk_edge, w_lead, w_trail, w_sample, w_shift;
  assign w_sclk_edge = w_sclk_rise | w_sclk_fall;
  assign w_lead      = w_sclk_edge & (w_sclk_s != CPOL);
  assign w_trail     = w_sclk_edge & (w_sclk_s == CPOL);
  assign w_sample    = CPHA ? w_trail : w_lead;
  assign w_shift     = CPHA ? w_lead  : w_trail;

  state_t r_state, w_state_nxt;
  logic   w_take, w_smp_en, w_shf_en, w_end, w_start;

  logic [7:0] r_tx_buf, r_tx_sh, r_rx_sh, r_rx_data;
  logic [3:0] r_bit_cnt;
  logic       r_tx_empty, r_miso, r_miso_oe, r_byte_done, r_rx_valid;
  logic       r_reload_pend, r_first, r_undr_pend;
  logic [2:0] r_err, w_err_nxt;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state and per-cycle datapath enables.
  always_comb begin
    w_state_nxt = r_state;
    w_take      = 1'b0;
    w_smp_en    = 1'b0;
    w_shf_en    = 1'b0;
    w_end       = 1'b0;
    w_start     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_cs_fall) begin
          w_start     = 1'b1;
          w_state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        w_take      = 1'b1;
        w_state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (w_cs_rise) begin
          w_end       = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_smp_en = w_sample;
          w_shf_en = w_shift;
          w_take   = w_shift & r_reload_pend;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // A reload prefers the buffered byte, then a same-cycle tx_load, then the idle byte.
  logic       w_buf_full, w_undr, w_ovf;
  logic [7:0] w_tx_src, w_rx_nxt;
  assign w_buf_full = ~r_tx_empty;
  assign w_tx_src   = w_buf_full ? r_tx_buf : (tx_load ? tx_data : IDLE_BYTE);
  assign w_undr     = ~w_buf_full & ~tx_load;
  assign w_ovf      = tx_load & w_buf_full & ~w_take;
  assign w_rx_nxt   = {r_rx_sh[6:0], w_mosi_s};

  // One-entry transmit buffer; a load coinciding with a reload of a full buffer stays pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_buf   <= '0;
      r_tx_empty <= 1'b1;
    end else if (w_take) begin
      if (w_buf_full && tx_load) begin
        r_tx_buf   <= tx_data;
        r_tx_empty <= 1'b0;
      end else begin
        r_tx_empty <= 1'b1;
      end
    end else if (tx_load) begin
      r_tx_buf   <= tx_data;
      r_tx_empty <= 1'b0;
    end
  end

  // Underrun from a mid-frame reload only counts once that byte actually starts clocking,
  // so the reload after the final byte of a frame does not flag an error.
  always_comb begin
    w_err_nxt = w_start ? 3'b000 : r_err;
    if (w_ovf) w_err_nxt[ERR_OVF] = 1'b1;
    if ((r_state == ST_LOAD && w_undr) || (w_smp_en && r_undr_pend)) w_err_nxt[ERR_UNDR] = 1'b1;
    if (w_end && r_bit_cnt != 4'd0) w_err_nxt[ERR_ABORT] = 1'b1;
  end

  // Sticky error register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_err <= '0;
    else        r_err <= w_err_nxt;
  end

  // Shift registers, bit counter and MISO/rx outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_sh       <= '0;
      r_rx_sh       <= '0;
      r_rx_data     <= '0;
      r_bit_cnt     <= '0;
      r_miso        <= 1'b0;
      r_miso_oe     <= 1'b0;
      r_byte_done   <= 1'b0;
      r_rx_valid    <= 1'b0;
      r_reload_pend <= 1'b0;
      r_first       <= 1'b0;
      r_undr_pend   <= 1'b0;
    end else begin
      r_byte_done <= 1'b0;
      r_rx_valid  <= r_byte_done;
      if (r_state == ST_LOAD) begin
        r_tx_sh       <= w_tx_src;
        r_miso        <= w_tx_src[7];
        r_miso_oe     <= 1'b1;
        r_bit_cnt     <= '0;
        r_first       <= CPHA;
        r_reload_pend <= 1'b0;
        r_undr_pend   <= 1'b0;
      end else if (w_end) begin
        r_miso_oe     <= 1'b0;
        r_bit_cnt     <= '0;
        r_first       <= 1'b0;
        r_reload_pend <= 1'b0;
        r_undr_pend   <= 1'b0;
      end else begin
        if (w_smp_en) begin
          r_rx_sh     <= w_rx_nxt;
          r_undr_pend <= 1'b0;
          if (r_bit_cnt == LAST_BIT) begin
            r_rx_data     <= w_rx_nxt;
            r_byte_done   <= 1'b1;
            r_bit_cnt     <= '0;
            r_reload_pend <= 1'b1;
          end else begin
            r_bit_cnt <= r_bit_cnt + 4'd1;
          end
        end
        if (w_shf_en) begin
          if (r_reload_pend) begin
            r_tx_sh       <= w_tx_src;
            r_miso        <= w_tx_src[7];
            r_reload_pend <= 1'b0;
            r_undr_pend   <= w_undr;
          end else if (r_first) begin
            r_first <= 1'b0;
            r_miso  <= r_tx_sh[7];
          end else begin
            r_tx_sh <= {r_tx_sh[6:0], 1'b0};
            r_miso  <= r_tx_sh[6];
          end
        end
      end
    end
  end

  assign miso     = r_miso;
  assign miso_oe  = r_miso_oe;
  assign tx_empty = r_tx_empty;
  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;
  assign busy     = ~w_cs_s;
  assign err      = r_err;

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: one instance per CPOL/CPHA mode driven by a bit-banged master at clk/8.
module tb_spi_slave;

  localparam int HALF = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       mosi = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       sclk_a [4];
  logic       cs_n_a [4];
  logic       tx_load_a [4];
  logic       miso_a [4];
  logic       miso_oe_a [4];
  logic       tx_empty_a [4];
  logic [7:0] rx_data_a [4];
  logic       rx_valid_a [4];
  logic       busy_a [4];
  logic [2:0] err_a [4];

  int         checks = 0;
  int         errors = 0;
  int         rxv_cnt [4] = '{default: 0};
  logic [7:0] rx_hist [4][16];

  always #5 clk = ~clk;

  for (genvar m = 0; m < 4; m++) begin : g_dut
    spi_slave #(.CPOL(((m / 2) % 2) == 1), .CPHA((m % 2) == 1)) u_dut (
      .clk(clk), .rst_n(rst_n), .sclk(sclk_a[m]), .cs_n(cs_n_a[m]), .mosi(mosi),
      .miso(miso_a[m]), .miso_oe(miso_oe_a[m]), .tx_data(tx_data), .tx_load(tx_load_a[m]),
      .tx_empty(tx_empty_a[m]), .rx_data(rx_data_a[m]), .rx_valid(rx_valid_a[m]),
      .busy(busy_a[m]), .err(err_a[m])
    );
  end

  // Log every received byte per instance.
  always @(posedge clk) begin
    for (int m = 0; m < 4; m++) begin
      if (rx_valid_a[m]) begin
        rx_hist[m][rxv_cnt[m] % 16] <= rx_data_a[m];
        rxv_cnt[m] <= rxv_cnt[m] + 1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic load_tx(input int m, input logic [7:0] d);
    tx_data      = d;
    tx_load_a[m] = 1'b1;
    @(negedge clk);
    tx_load_a[m] = 1'b0;
  endtask

  // Half an SCLK period; optionally feeds the next tx byte in its first cycle.
  task automatic wait_half(input int m, input bit ld, input logic [7:0] d);
    for (int k = 0; k < HALF; k++) begin
      if (ld && k == 0) begin
        chk("tx_empty_before_feed", tx_empty_a[m], 1);
        tx_data      = d;
        tx_load_a[m] = 1'b1;
      end else begin
        tx_load_a[m] = 1'b0;
      end
      @(negedge clk);
    end
    tx_load_a[m] = 1'b0;
  endtask

  // Master: nbits bits of mo (MSB first, byte0 in [31:24]); MISO bits returned in mi.
  task automatic spi_frame(input int m, input int nbits, input logic [31:0] mo,
                           input bit feed, input logic [31:0] fb,
                           output logic [31:0] mi, output logic oe_first);
    bit         cpol, cpha, ld;
    logic [7:0] nb;
    cpol = m[1];
    cpha = m[0];
    mi = '0;
    cs_n_a[m] = 1'b0;
    if (!cpha) mosi = mo[31];
    repeat (8) @(negedge clk);
    oe_first = miso_oe_a[m];
    for (int j = 0; j < nbits; j++) begin
      ld = feed && (j % 8 == 3) && ((j / 8) + 1 < nbits / 8);
      nb = 8'h00;
      if (ld) nb = fb[23 - 8 * (j / 8) -: 8];
      if (!cpha) begin
        mi[31 - j] = miso_a[m];
        sclk_a[m]  = !cpol;
        wait_half(m, ld, nb);
        sclk_a[m] = cpol;
        if (j + 1 < nbits) mosi = mo[30 - j];
        wait_half(m, 1'b0, 8'h00);
      end else begin
        sclk_a[m] = !cpol;
        mosi      = mo[31 - j];
        wait_half(m, ld, nb);
        mi[31 - j] = miso_a[m];
        sclk_a[m]  = cpol;
        wait_half(m, 1'b0, 8'h00);
      end
    end
    cs_n_a[m] = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  typedef struct {
    int         mode;
    bit         has_tx;
    logic [7:0] tx;
    logic [7:0] mosi_b;
    logic [7:0] exp_miso;
    logic [7:0] exp_rx;
    logic [2:0] exp_err;
  } vec_t;

  vec_t       vecs [6];
  logic [31:0] mi;
  logic        oe;
  int          c0;

  initial begin
    vecs[0] = '{0, 1'b1, 8'hA5, 8'h3C, 8'hA5, 8'h3C, 3'b000};
    vecs[1] = '{0, 1'b0, 8'h00, 8'h81, 8'hFF, 8'h81, 3'b010};
    vecs[2] = '{1, 1'b1, 8'h0F, 8'hF0, 8'h0F, 8'hF0, 3'b000};
    vecs[3] = '{2, 1'b1, 8'h80, 8'h01, 8'h80, 8'h01, 3'b000};
    vecs[4] = '{3, 1'b0, 8'h00, 8'h7E, 8'hFF, 8'h7E, 3'b010};
    vecs[5] = '{3, 1'b1, 8'h00, 8'hFF, 8'h00, 8'hFF, 3'b000};

    for (int m = 0; m < 4; m++) begin
      sclk_a[m]    = ((m / 2) % 2) == 1;
      cs_n_a[m]    = 1'b1;
      tx_load_a[m] = 1'b0;
    end
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Reset values: {miso, oe, tx_empty, rx_valid, busy, err, rx_data}.
    for (int m = 0; m < 4; m++)
      chk("reset_state", {miso_a[m], miso_oe_a[m], tx_empty_a[m], rx_valid_a[m],
                          busy_a[m], err_a[m], rx_data_a[m]}, 16'h2000);

    // Single-byte frames across modes.
    for (int v = 0; v < 6; v++) begin
      if (vecs[v].has_tx) load_tx(vecs[v].mode, vecs[v].tx);
      c0 = rxv_cnt[vecs[v].mode];
      spi_frame(vecs[v].mode, 8, {vecs[v].mosi_b, 24'h0}, 1'b0, 32'h0, mi, oe);
      repeat (4) @(negedge clk);
      chk("vec_miso", mi[31:24], vecs[v].exp_miso);
      chk("vec_oe_in_frame", oe, 1);
      chk("vec_rx_count", rxv_cnt[vecs[v].mode] - c0, 1);
      chk("vec_rx_data", rx_data_a[vecs[v].mode], vecs[v].exp_rx);
      chk("vec_err", err_a[vecs[v].mode], vecs[v].exp_err);
      chk("vec_oe_after", miso_oe_a[vecs[v].mode], 0);
    end

    // Three back-to-back bytes per mode, next tx byte fed once the buffer frees.
    for (int m = 0; m < 4; m++) begin
      load_tx(m, 8'h11);
      c0 = rxv_cnt[m];
      spi_frame(m, 24, 32'hC1C2C300, 1'b1, 32'h11223300, mi, oe);
      repeat (4) @(negedge clk);
      chk("multi_miso", mi[31:8], 24'h112233);
      chk("multi_rx_count", rxv_cnt[m] - c0, 3);
      chk("multi_rx0", rx_hist[m][(c0 + 0) % 16], 8'hC1);
      chk("multi_rx1", rx_hist[m][(c0 + 1) % 16], 8'hC2);
      chk("multi_rx2", rx_hist[m][(c0 + 2) % 16], 8'hC3);
      chk("multi_err", err_a[m], 3'b000);
    end

    // Overwrite of a full buffer: the later byte wins; the flag is cleared when the frame starts.
    load_tx(0, 8'h55);
    load_tx(0, 8'hAA);
    chk("ovf_flag", err_a[0], 3'b001);
    chk("ovf_tx_empty", tx_empty_a[0], 0);
    spi_frame(0, 8, 32'h42000000, 1'b0, 32'h0, mi, oe);
    repeat (4) @(negedge clk);
    chk("ovf_miso", mi[31:24], 8'hAA);
    chk("ovf_err_after", err_a[0], 3'b000);
    chk("ovf_rx_data", rx_data_a[0], 8'h42);

    // Abort after 5 SCLK cycles.
    load_tx(3, 8'h3C);
    c0 = rxv_cnt[3];
    spi_frame(3, 5, 32'hF0000000, 1'b0, 32'h0, mi, oe);
    chk("abort_oe_low", miso_oe_a[3], 0);
    chk("abort_err", err_a[3], 3'b100);
    repeat (6) @(negedge clk);
    chk("abort_no_rx", rxv_cnt[3] - c0, 0);
    chk("abort_not_busy", busy_a[3], 0);

    // Reset mid-byte with an underrun flagged and a byte pending, then a clean frame.
    cs_n_a[0] = 1'b0;
    mosi = 1'b1;
    repeat (8) @(negedge clk);
    load_tx(0, 8'h99);
    for (int k = 0; k < 3; k++) begin
      sclk_a[0] = 1'b1;
      wait_half(0, 1'b0, 8'h00);
      sclk_a[0] = 1'b0;
      wait_half(0, 1'b0, 8'h00);
    end
    chk("pre_reset_busy", busy_a[0], 1);
    chk("pre_reset_err", err_a[0], 3'b010);
    rst_n = 1'b0;
    #1;
    chk("midframe_reset", {miso_a[0], miso_oe_a[0], tx_empty_a[0], rx_valid_a[0],
                           busy_a[0], err_a[0], rx_data_a[0]}, 16'h2000);
    @(negedge clk);
    cs_n_a[0] = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    load_tx(0, 8'h5A);
    c0 = rxv_cnt[0];
    spi_frame(0, 8, 32'h96000000, 1'b0, 32'h0, mi, oe);
    repeat (4) @(negedge clk);
    chk("post_reset_miso", mi[31:24], 8'h5A);
    chk("post_reset_rx_count", rxv_cnt[0] - c0, 1);
    chk("post_reset_rx", rx_data_a[0], 8'h96);
    chk("post_reset_err", err_a[0], 3'b000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
